update1_issue_wb: RTL and testbench

- Instruction issue and write-back stage that sits directly upstream of the mini-core's combinational 16-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from an 8x16 register file, with a bypass from the in-flight result.
- Drives opcode/a/b into the ALU for one cycle, then writes the ALU result back to the register file.

---
 rtl/update1_pkg.sv | 28 ++
 rtl/update1_regfile.sv | 38 +++
 rtl/update1_issue_wb.sv | 120 ++++++++++++
 tb/tb_update1_issue_wb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/update1_pkg.sv
// Shared constants for the update1 issue/write-back slice: default widths,
// instruction field layout and the ALU opcode encodings.
package update1_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREGS  = 8;
    localparam int DEF_CNT_W  = 16;
    localparam int REG_W      = 3;
    localparam int INSTR_W    = 16;

    localparam int OPC_LSB = 13;
    localparam int OPC_W   = 3;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 7;
    localparam int IMM_BIT = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_W   = 6;

    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPC_W-1:0] OP_AND = 3'b010;
    localparam logic [OPC_W-1:0] OP_OR  = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_MUL = 3'b101;
    localparam logic [OPC_W-1:0] OP_INC = 3'b110;
    localparam logic [OPC_W-1:0] OP_DEC = 3'b111;

endpackage

// File: rtl/update1_regfile.sv
// Register file for the update1 slice: two combinational operand read ports,
// one debug read port and one synchronous write port, cleared by async reset.
module update1_regfile
    import update1_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/update1_issue_wb.sv
// Issue and write-back stage feeding the mini-core's combinational ALU.
// Optional macro UPDATE1_IMM_EN: instr[6] selects a zero-extended 6-bit immediate for b.
module update1_issue_wb
    import update1_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               halt,
    output logic [OPC_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               wb_valid,
    output logic [REG_W-1:0]   wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic [CNT_W-1:0]   retire_count,
    input  logic [REG_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [OPC_W-1:0]  opc;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic              accept;
    logic              iss_valid;
    logic [REG_W-1:0]  iss_rd;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    assign opc = instr[OPC_LSB +: OPC_W];
    assign rd  = instr[RD_LSB  +: REG_W];
    assign rs1 = instr[RS1_LSB +: REG_W];
    assign rs2 = instr[RS2_LSB +: REG_W];

    assign instr_ready = !halt && !rst;
    assign accept      = instr_valid && instr_ready;

    update1_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (iss_valid),
        .waddr    (iss_rd),
        .wdata    (alu_result),
        .raddr_a  (rs1),
        .rdata_a  (rf_a),
        .raddr_b  (rs2),
        .rdata_b  (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // The in-flight result is written this same edge, so a reader must take it from the ALU.
    always_comb begin
        op_a = (iss_valid && iss_rd == rs1) ? alu_result : rf_a;
        op_b = (iss_valid && iss_rd == rs2) ? alu_result : rf_b;
`ifdef UPDATE1_IMM_EN
        if (instr[IMM_BIT]) begin
            op_b = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
        end
`endif
    end

`ifdef UPDATE1_IMM_EN
    logic unused_bits;
    assign unused_bits = ^instr[RS2_LSB-1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{instr[IMM_BIT], instr[RS2_LSB-1:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid  <= 1'b0;
            iss_rd     <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            iss_valid <= accept;
            if (accept) begin
                iss_rd     <= rd;
                alu_opcode <= opc;
                alu_a      <= op_a;
                alu_b      <= op_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            retire_count <= '0;
        end else begin
            wb_valid <= iss_valid;
            if (iss_valid) begin
                wb_rd        <= iss_rd;
                wb_data      <= alu_result;
                retire_count <= retire_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_update1_issue_wb.sv
// Scoreboard bench for update1_issue_wb: an in-order architectural model predicts
// each write-back, and a negedge monitor compares whatever the DUT retires.
module tb_update1_issue_wb;
    import update1_pkg::*;

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        halt;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] retire_count;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] rf_model [8];
    wb_t         exp_q [$];
    logic [15:0] mon_retire;
    wb_t         mon_e;

    update1_issue_wb dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .halt         (halt),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .retire_count (retire_count),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_MUL:  return 16'(a * b);
            OP_INC:  return a + 16'd1;
            default: return a - 16'd1;
        endcase
    endfunction

    // The external ALU the stage drives.
    always_comb alu_result = alu_fn(alu_opcode, alu_a, alu_b);

    function automatic logic [15:0] enc(input logic [2:0] op, input int rd, input int rs1, input int rs2);
        return {op, 3'(rd), 3'(rs1), 1'b0, 3'(rs2), 3'b000};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Architectural model: each accepted instruction executes fully before the next.
    task automatic modelIssue(input logic [15:0] ins);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        wb_t e;
        a = rf_model[ins[9:7]];
        b = rf_model[ins[5:3]];
`ifdef UPDATE1_IMM_EN
        if (ins[6]) b = {10'd0, ins[5:0]};
`endif
        r = alu_fn(ins[15:13], a, b);
        rf_model[ins[12:10]] = r;
        e.rd = ins[12:10];
        e.data = r;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] ins);
        instr_valid = v;
        instr = ins;
        if (v && !halt) modelIssue(ins);
        tick();
    endtask

    task automatic drain();
        instr_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        checkOutput("drain_pending", exp_q.size(), 0);
    endtask

    task automatic checkReg(input int idx, input logic [15:0] exp);
        dbg_addr = 3'(idx);
        #1;
        checkOutput($sformatf("dbg_r%0d", idx), dbg_data, exp);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        halt = 1'b0;
        instr_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) rf_model[i] = '0;
        #1;
        checkOutput("rst_instr_ready", instr_ready, 0);
        checkOutput("rst_alu_opcode", alu_opcode, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_wb_rd", wb_rd, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_retire", retire_count, 0);
        for (int i = 0; i < 7; i++) checkReg(i, 16'd0);
        tick();
        dbg_addr = 3'd7;
        #1;
        checkOutput("dbg_r7", dbg_data, 0);
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every retired write-back must match the oldest predicted one.
    always @(negedge clk) begin
        if (rst) begin
            mon_retire = '0;
        end else if (wb_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_wb", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_retire = mon_retire + 16'd1;
                checkOutput("wb_rd", wb_rd, mon_e.rd);
                checkOutput("wb_data", wb_data, mon_e.data);
                checkOutput("retire_count", retire_count, mon_retire);
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] imm_ins;
        rst = 1'b1;
        halt = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        dbg_addr = '0;
        tick();
        applyReset();

        // Randomized traffic with occasional halts.
        for (int n = 0; n < 300; n++) begin
            halt = ($urandom_range(0, 7) == 0);
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom));
        end
        halt = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) checkReg(i, rf_model[i]);

        // Reset with instructions in flight.
        applyStimulus(1'b1, enc(OP_INC, 1, 1, 0));
        applyStimulus(1'b1, enc(OP_INC, 2, 1, 0));
        applyReset();

        // Back-to-back dependent INCs exercise the bypass.
        applyStimulus(1'b1, enc(OP_INC, 1, 0, 0));
        applyStimulus(1'b1, enc(OP_INC, 1, 1, 0));
        applyStimulus(1'b1, enc(OP_INC, 2, 1, 0));
        drain();
        checkReg(1, 16'd2);
        checkReg(2, 16'd3);
        checkOutput("inc_retire", retire_count, 3);

        applyStimulus(1'b1, enc(OP_ADD, 3, 1, 2));
        applyStimulus(1'b1, enc(OP_MUL, 4, 3, 3));
        checkOutput("mul_alu_a", alu_a, 5);
        checkOutput("mul_alu_b", alu_b, 5);
        drain();
        checkReg(3, 16'd5);
        checkReg(4, 16'd25);

        // Halt right after a SUB is accepted.
        applyStimulus(1'b1, enc(OP_SUB, 5, 4, 3));
        halt = 1'b1;
        instr_valid = 1'b1;
        instr = enc(OP_ADD, 6, 1, 2);
        #1;
        checkOutput("halt_instr_ready", instr_ready, 0);
        tick();
        tick();
        checkOutput("halt_sub_retired", exp_q.size(), 0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("halt_no_wb", wb_valid, 0);
            tick();
        end
        halt = 1'b0;
        applyStimulus(1'b1, enc(OP_ADD, 6, 1, 2));
        drain();
        checkReg(5, 16'd20);
        checkReg(6, 16'd5);

        // Immediate encoding: rs2 field is 7 when instr[5:0] = 0x3F.
        applyReset();
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, enc(OP_INC, 1, 1, 0));
        imm_ins = {OP_ADD, 3'd2, 3'd1, 7'h7F};
        applyStimulus(1'b1, imm_ins);
        drain();
        checkReg(1, 16'd5);
`ifdef UPDATE1_IMM_EN
        checkReg(2, 16'd68);
`else
        checkReg(2, 16'd5);
`endif

        // Retire counter wrap.
        applyReset();
        for (int k = 0; k < 65535; k++) applyStimulus(1'b1, enc(OP_INC, 1, 1, 0));
        drain();
        checkOutput("pre_wrap_retire", retire_count, 16'hFFFF);
        checkReg(1, 16'hFFFF);
        applyStimulus(1'b1, enc(OP_INC, 5, 0, 0));
        drain();
        checkOutput("wrap_retire", retire_count, 0);
        checkReg(1, 16'hFFFF);
        checkReg(5, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
